// File: rtl/arb_mux_pkg.sv
// -----------------------------------------------------------------------------
// arb_mux_pkg
// Shared definitions for the transaction-layer arbitrating multiplexer.
// Holds the one-hot layer state encodings, which the layer FSM also uses,
// and a decode helper that says whether a state code permits transfers.
// -----------------------------------------------------------------------------
package arb_mux_pkg;

    // One-hot layer state encodings
    localparam logic [3:0] STATE_RESET  = 4'b0001;
    localparam logic [3:0] STATE_INIT   = 4'b0010;
    localparam logic [3:0] STATE_IDLE   = 4'b0100;
    localparam logic [3:0] STATE_ACTIVE = 4'b1000;

    // Transfers are only allowed in IDLE or ACTIVE. Every other code,
    // including zero and non-one-hot codes, blocks transfers.
    function automatic logic state_allows_xfer(input logic [3:0] st);
        logic ok;
        case (st)
            STATE_IDLE:   ok = 1'b1;
            STATE_ACTIVE: ok = 1'b1;
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // RESET is the only state code that clears the datapath
    function automatic logic state_is_reset(input logic [3:0] st);
        logic hit;
        case (st)
            STATE_RESET: hit = 1'b1;
            default:     hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Grant logic for arb_mux. Holds the round-robin pointer, searches the request
// vector (rotated after the pointer when RR=1, lowest index first when RR=0)
// and produces a one-hot grant plus the granted index.
//
// Ports:
//   clk           in   clock, rising edge
//   clear_i       in   synchronous clear of the pointer (to CHANNELS-1)
//   enable_i      in   a grant may be issued this cycle
//   req_i         in   CHANNELS request bits
//   grant_o       out  one-hot grant, all zeros when no grant
//   grant_vld_o   out  a grant is issued this cycle
//   grant_idx_o   out  index of the granted channel (meaningful with grant_vld_o)
// -----------------------------------------------------------------------------
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int CHANNELS = 5,
    parameter int RR       = 1,
    parameter int IDX_W    = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                clear_i,
    input  logic                enable_i,
    input  logic [CHANNELS-1:0] req_i,
    output logic [CHANNELS-1:0] grant_o,
    output logic                grant_vld_o,
    output logic [IDX_W-1:0]    grant_idx_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] sel_s;
    logic             found_s;
    logic             grant_vld_s;
    int               cand_s;

    // Winner search: rotate past the pointer (RR) or lowest index (fixed)
    always_comb begin
        sel_s   = '0;
        found_s = 1'b0;
        cand_s  = 0;
        if (RR != 0) begin
            // Start one past the pointer, so the last winner has lowest priority
            for (int i = 1; i <= CHANNELS; i++) begin
                cand_s = (int'(ptr_q) + i) % CHANNELS;
                if (!found_s && req_i[cand_s]) begin
                    found_s = 1'b1;
                    sel_s   = cand_s[IDX_W-1:0];
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            // Descending scan so the lowest requesting index is written last
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                if (req_i[i]) begin
                    found_s = 1'b1;
                    sel_s   = IDX_W'(i);
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    assign grant_vld_s = enable_i & found_s;

    // One-hot grant expansion; zero when no grant is issued
    always_comb begin
        grant_o = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant_vld_s && (sel_s == IDX_W'(k))) begin
                grant_o[k] = 1'b1;
            end else begin
                grant_o[k] = 1'b0;
            end
        end
    end

    // Pointer next state: follows the winner, holds otherwise
    always_comb begin
        if (grant_vld_s) begin
            ptr_d = sel_s;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register; reset value CHANNELS-1 makes channel 0 win first
    always_ff @(posedge clk) begin
        if (clear_i) begin
            ptr_q <= IDX_W'(CHANNELS - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant_vld_o = grant_vld_s;
    assign grant_idx_o = sel_s;

endmodule

// File: rtl/arb_mux.sv
// -----------------------------------------------------------------------------
// arb_mux
// Arbitrating multiplexer between the per-class FIFOs and the outgoing stream
// FIFO. Picks one requesting channel per cycle (round-robin or fixed priority),
// pops it combinationally and registers its word onto the output stream.
// Gated by the one-hot layer state and downstream backpressure.
//
// Ports:
//   clk        in   clock, rising edge
//   reset_L    in   synchronous active-low reset
//   state      in   one-hot layer state (RESET/INIT/IDLE/ACTIVE)
//   in_data    in   CHANNELS*WIDTH flattened channel words
//   in_valid   in   per-channel word available
//   out_ready  in   downstream can accept a word
//   in_pop     out  one-hot combinational pop of the granted channel
//   data       out  registered output word
//   valid      out  registered, data is new this cycle
//   grant_idx  out  registered index of the channel that produced data
// -----------------------------------------------------------------------------
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 5,
    parameter int IDX_W    = $clog2(CHANNELS),
    parameter int RR       = 1
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic [3:0]                state,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic                      out_ready,
    output logic [CHANNELS-1:0]       in_pop,
    output logic [WIDTH-1:0]          data,
    output logic                      valid,
    output logic [IDX_W-1:0]          grant_idx
);

    logic             clear_s;
    logic             xfer_en_s;
    logic             grant_vld_s;
    logic [IDX_W-1:0] arb_idx_s;
    logic [WIDTH-1:0] sel_word_s;

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;
    logic             valid_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    // A low reset_L blocks transfers directly, so a pop can never coincide
    // with a clearing edge.
    assign clear_s   = (~reset_L) | state_is_reset(state);
    assign xfer_en_s = reset_L & state_allows_xfer(state) & out_ready;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .RR       (RR),
        .IDX_W    (IDX_W)
    ) u_arb (
        .clk         (clk),
        .clear_i     (clear_s),
        .enable_i    (xfer_en_s),
        .req_i       (in_valid),
        .grant_o     (in_pop),
        .grant_vld_o (grant_vld_s),
        .grant_idx_o (arb_idx_s)
    );

    // Slice the flattened input bus by the arbiter's chosen index
    always_comb begin
        sel_word_s = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (arb_idx_s == IDX_W'(k)) begin
                sel_word_s = in_data[k*WIDTH +: WIDTH];
            end else begin
                sel_word_s = sel_word_s;
            end
        end
    end

    // Output next state: load on grant, otherwise drop valid and hold the rest
    always_comb begin
        if (grant_vld_s) begin
            data_d  = sel_word_s;
            valid_d = 1'b1;
            idx_d   = arb_idx_s;
        end else begin
            data_d  = data_q;
            valid_d = 1'b0;
            idx_d   = idx_q;
        end
    end

    // Output register bank
    always_ff @(posedge clk) begin
        if (clear_s) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign grant_idx = idx_q;

endmodule

// File: tb/tb_arb_mux.sv
module tb_arb_mux;
    import arb_mux_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_L;
    logic [3:0] state;

    // Round-robin instance, CHANNELS=5, WIDTH=5
    logic [24:0] rr_data;
    logic [4:0]  rr_valid;
    logic        rr_ready;
    logic [4:0]  rr_pop;
    logic [4:0]  rr_out;
    logic        rr_ov;
    logic [2:0]  rr_idx;

    // Fixed-priority instance, CHANNELS=5, WIDTH=5
    logic [24:0] fp_data;
    logic [4:0]  fp_valid;
    logic        fp_ready;
    logic [4:0]  fp_pop;
    logic [4:0]  fp_out;
    logic        fp_ov;
    logic [2:0]  fp_idx;

    // Round-robin instance, CHANNELS=3, WIDTH=8
    logic [23:0] c3_data;
    logic [2:0]  c3_valid;
    logic        c3_ready;
    logic [2:0]  c3_pop;
    logic [7:0]  c3_out;
    logic        c3_ov;
    logic [1:0]  c3_idx;

    arb_mux #(.WIDTH(5), .CHANNELS(5), .RR(1)) dut_rr (
        .clk(clk), .reset_L(reset_L), .state(state), .in_data(rr_data),
        .in_valid(rr_valid), .out_ready(rr_ready), .in_pop(rr_pop),
        .data(rr_out), .valid(rr_ov), .grant_idx(rr_idx)
    );

    arb_mux #(.WIDTH(5), .CHANNELS(5), .RR(0)) dut_fp (
        .clk(clk), .reset_L(reset_L), .state(state), .in_data(fp_data),
        .in_valid(fp_valid), .out_ready(fp_ready), .in_pop(fp_pop),
        .data(fp_out), .valid(fp_ov), .grant_idx(fp_idx)
    );

    arb_mux #(.WIDTH(8), .CHANNELS(3), .RR(1)) dut_c3 (
        .clk(clk), .reset_L(reset_L), .state(state), .in_data(c3_data),
        .in_valid(c3_valid), .out_ready(c3_ready), .in_pop(c3_pop),
        .data(c3_out), .valid(c3_ov), .grant_idx(c3_idx)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0] st;
        logic       rst_n;
        logic [4:0] vld;
        logic       rdy;
        logic [4:0] pop;
        logic       ov;
        logic [4:0] od;
        logic [2:0] oi;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    initial begin
        // Channel words: channel k carries 5'h10 + k (5-ch) or 8'hA0 + k (3-ch)
        rr_data  = {5'h14, 5'h13, 5'h12, 5'h11, 5'h10};
        fp_data  = {5'h14, 5'h13, 5'h12, 5'h11, 5'h10};
        c3_data  = {8'hA2, 8'hA1, 8'hA0};
        rr_valid = 5'b00000; rr_ready = 1'b0;
        fp_valid = 5'b00000; fp_ready = 1'b1;
        c3_valid = 3'b000;   c3_ready = 1'b1;
        reset_L  = 1'b0;
        state    = STATE_RESET;

        //             state         rst   in_valid  rdy   exp_pop   ov    data   idx
        vecs[0]  = '{STATE_RESET,  1'b0, 5'b00101, 1'b1, 5'b00000, 1'b0, 5'h00, 3'd0};
        // Round-robin alternation between channels 0 and 2
        vecs[1]  = '{STATE_IDLE,   1'b1, 5'b00101, 1'b1, 5'b00001, 1'b1, 5'h10, 3'd0};
        vecs[2]  = '{STATE_IDLE,   1'b1, 5'b00101, 1'b1, 5'b00100, 1'b1, 5'h12, 3'd2};
        vecs[3]  = '{STATE_IDLE,   1'b1, 5'b00101, 1'b1, 5'b00001, 1'b1, 5'h10, 3'd0};
        vecs[4]  = '{STATE_IDLE,   1'b1, 5'b00101, 1'b1, 5'b00100, 1'b1, 5'h12, 3'd2};
        // Backpressure on a lone requester
        vecs[5]  = '{STATE_ACTIVE, 1'b1, 5'b00010, 1'b1, 5'b00010, 1'b1, 5'h11, 3'd1};
        vecs[6]  = '{STATE_ACTIVE, 1'b1, 5'b00010, 1'b0, 5'b00000, 1'b0, 5'h11, 3'd1};
        vecs[7]  = '{STATE_ACTIVE, 1'b1, 5'b00010, 1'b0, 5'b00000, 1'b0, 5'h11, 3'd1};
        vecs[8]  = '{STATE_ACTIVE, 1'b1, 5'b00010, 1'b1, 5'b00010, 1'b1, 5'h11, 3'd1};
        // Wrap-around: put pointer at 4, then 10001 gives 0 then 4
        vecs[9]  = '{STATE_ACTIVE, 1'b1, 5'b10000, 1'b1, 5'b10000, 1'b1, 5'h14, 3'd4};
        vecs[10] = '{STATE_ACTIVE, 1'b1, 5'b10001, 1'b1, 5'b00001, 1'b1, 5'h10, 3'd0};
        vecs[11] = '{STATE_ACTIVE, 1'b1, 5'b10001, 1'b1, 5'b10000, 1'b1, 5'h14, 3'd4};
        // INIT and illegal codes block; pointer held at 4
        vecs[12] = '{STATE_INIT,   1'b1, 5'b10001, 1'b1, 5'b00000, 1'b0, 5'h14, 3'd4};
        vecs[13] = '{4'b0110,      1'b1, 5'b10001, 1'b1, 5'b00000, 1'b0, 5'h14, 3'd4};
        vecs[14] = '{4'b0000,      1'b1, 5'b10001, 1'b1, 5'b00000, 1'b0, 5'h14, 3'd4};
        vecs[15] = '{STATE_ACTIVE, 1'b1, 5'b10001, 1'b1, 5'b00001, 1'b1, 5'h10, 3'd0};
        // reset_L pulse during a grant; then lowest requester (1) wins
        vecs[16] = '{STATE_ACTIVE, 1'b0, 5'b10001, 1'b1, 5'b00000, 1'b0, 5'h00, 3'd0};
        vecs[17] = '{STATE_ACTIVE, 1'b1, 5'b10110, 1'b1, 5'b00010, 1'b1, 5'h11, 3'd1};
        vecs[18] = '{STATE_ACTIVE, 1'b1, 5'b00000, 1'b1, 5'b00000, 1'b0, 5'h11, 3'd1};
        vecs[19] = '{STATE_RESET,  1'b1, 5'b11111, 1'b1, 5'b00000, 1'b0, 5'h00, 3'd0};

        @(posedge clk); #1;

        for (int v = 0; v < NV; v++) begin
            state    = vecs[v].st;
            reset_L  = vecs[v].rst_n;
            rr_valid = vecs[v].vld;
            rr_ready = vecs[v].rdy;
            #1;
            check($sformatf("v%0d rr in_pop", v), 32'(rr_pop), 32'(vecs[v].pop));
            @(posedge clk); #1;
            check($sformatf("v%0d rr valid", v), 32'(rr_ov), 32'(vecs[v].ov));
            check($sformatf("v%0d rr data", v), 32'(rr_out), 32'(vecs[v].od));
            check($sformatf("v%0d rr grant_idx", v), 32'(rr_idx), 32'(vecs[v].oi));
        end

        // Idle instances saw only RESET/blocked cycles or no requests
        check("fp reset valid", 32'(fp_ov), 32'd0);
        check("c3 reset valid", 32'(c3_ov), 32'd0);

        // Fixed priority: all requesting, channel 0 always wins
        rr_valid = 5'b00000;
        state    = STATE_ACTIVE;
        fp_valid = 5'b11111;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("fp c%0d in_pop", c), 32'(fp_pop), 32'h01);
            @(posedge clk); #1;
            check($sformatf("fp c%0d grant_idx", c), 32'(fp_idx), 32'd0);
            check($sformatf("fp c%0d valid", c), 32'(fp_ov), 32'd1);
            check($sformatf("fp c%0d data", c), 32'(fp_out), 32'h10);
        end
        fp_valid = 5'b10100;
        #1;
        check("fp low wins in_pop", 32'(fp_pop), 32'h04);
        @(posedge clk); #1;
        check("fp low wins grant_idx", 32'(fp_idx), 32'd2);
        check("fp low wins data", 32'(fp_out), 32'h12);
        fp_valid = 5'b00000;

        // 3-channel wrap: pointer reset to 2, requests 101 give 0, 2, 0
        c3_valid = 3'b101;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("c3 c%0d in_pop", c), 32'(c3_pop), (c == 1) ? 32'h4 : 32'h1);
            @(posedge clk); #1;
            check($sformatf("c3 c%0d grant_idx", c), 32'(c3_idx), (c == 1) ? 32'd2 : 32'd0);
            check($sformatf("c3 c%0d data", c), 32'(c3_out), (c == 1) ? 32'hA2 : 32'hA0);
            check($sformatf("c3 c%0d valid", c), 32'(c3_ov), 32'd1);
        end
        c3_valid = 3'b000;
        #1;
        check("c3 no req in_pop", 32'(c3_pop), 32'h0);
        @(posedge clk); #1;
        check("c3 no req valid", 32'(c3_ov), 32'd0);
        check("c3 no req data hold", 32'(c3_out), 32'hA0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised arbitrating multiplexer for the transaction layer. It merges CHANNELS upstream FIFO outputs of WIDTH bits into one registered stream and selects a source by fixed priority or round-robin arbitration. It honours downstream backpressure and pops the granted source. It is gated by the one-hot link state from the layer FSM and sits between the per-class FIFOs and the outgoing stream FIFO.

## Interface
Parameters:
- WIDTH, 5: data bits per channel.
- CHANNELS, 5: number of input channels, 2..16.
- IDX_W, $clog2(CHANNELS): width of the grant index.
- RR, 1: 1 selects round-robin arbitration; 0 selects fixed priority, where the lowest index wins.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- reset_L  in  1  synchronous, active-low reset.
- state  in  4  one-hot layer state: 0001 RESET, 0010 INIT, 0100 IDLE, 1000 ACTIVE.
- in_data  in  CHANNELS*WIDTH  flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  CHANNELS  channel k has a word available (its FIFO is not empty).
- out_ready  in  1  downstream can accept a word (its FIFO is not almost-full).
- in_pop  out  CHANNELS  combinational one-hot pop to the granted channel; all zeros when there is no grant.
- data  out  WIDTH  registered output word.
- valid  out  1  registered; data is new this cycle.
- grant_idx  out  IDX_W  registered index of the channel that produced data.

## Operation
- Enable: transfers are enabled only when state is 0100 or 1000 and reset_L is 1.
- Reset (reset_L=0 or state=0001) takes effect at the edge:
  - data=0, valid=0, grant_idx=0.
  - RR pointer=CHANNELS-1, so channel 0 is favoured first.
- INIT (0010) and any non-one-hot or zero state code:
  - valid<=0; data, grant_idx and pointer hold.
  - in_pop=0.
- Grant condition: enabled and out_ready=1 and |in_valid.
  - RR=1: the granted channel is the first requesting index strictly after the pointer, searching modulo CHANNELS.
  - RR=0: the granted channel is the lowest requesting index.
  - The pointer is updated only on a grant, to the granted index.
- On a grant to channel g:
  - in_pop[g]=1 in the same cycle.
  - At the edge: data<=in_data[g], valid<=1, grant_idx<=g.
- No grant (enabled but out_ready=0 or in_valid=0): valid<=0; data and grant_idx hold; pointer holds.
- At most one in_pop bit is set in any cycle. in_pop never asserts for a channel whose in_valid is 0.
- A lone requester is granted every cycle, including repeated grants to the same index.

## Timing
- Latency is 1 cycle, from a grant/in_pop cycle to valid/data at the next edge.
- Throughput is one word per cycle while out_ready=1.
- in_pop depends combinationally on in_valid, out_ready, state, reset_L and the pointer. It contains no combinational path from data or valid.
- When out_ready falls, no pop occurs in that cycle, and valid is 0 at the next edge.
  - The downstream almost-full threshold must therefore absorb 1 in-flight word.
- A state change to INIT or RESET in the same cycle as pending requests suppresses the pop. No word is lost or duplicated.
- reset_L low mid-stream clears valid at the next edge. Upstream words not popped are left in their FIFOs.

## Structure
- Shared package/include holds the state encodings (STATE_RESET, STATE_INIT, STATE_IDLE, STATE_ACTIVE) and is shared with the layer FSM.
- Sub-module rr_arbiter(CHANNELS, RR) contains the pointer register, the rotate-and-priority-encode logic, and the one-hot grant and index outputs.
- The top level holds the enable decode, the output register bank and the flattened-bus slicing.

## Test plan
- Reset, then state=0100 with in_valid=00101 and out_ready=1, RR=1: grants go 0, 2, 0, 2 on consecutive cycles. valid is 1 from the cycle after the first pop, and data matches each channel's word.
- RR=0 with in_valid=11111 held for 4 cycles: in_pop=00001 every cycle, and grant_idx stays 0.
- Backpressure: streaming with in_valid=00010, drop out_ready for 2 cycles.
  - in_pop=0 during those cycles, and valid=0 one edge later.
  - data holds its last value.
  - Pops resume on the cycle out_ready returns, with no words lost or duplicated.
- Wrap-around with CHANNELS=5, pointer at 4, in_valid=10001: the next grant is 0, then 4. Repeat with CHANNELS=3 and WIDTH=8 for the parameter sweep.
- state=0010 mid-stream with requests pending: in_pop=0, and valid falls after 1 edge. Returning to 1000 resumes from the held pointer.
- reset_L=0 for one cycle during a grant: the next edge gives data=0, valid=0, grant_idx=0, and the first grant afterwards goes to the lowest requesting index.
